// File: rtl/uart_cfg.sv
// Full-duplex UART with configurable data width, parity, stop bits and baud rate.
// TX and RX are independent FSMs; RX flags parity, framing and overrun errors.
//   state   | meaning
//   S_IDLE  | line idle, waiting for wr_en (TX) or a falling edge (RX)
//   S_START | start bit
//   S_DATA  | payload bits, LSB first
//   S_PAR   | parity bit (only when PARITY != 0)
//   S_STOP  | stop bit(s)
module uart_cfg #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk_50m,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_en,
  output logic                 Tx,
  output logic                 Tx_busy,
  input  logic                 Rx,
  output logic                 ready,
  input  logic                 ready_clr,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BIT_CLKS  = (CLK_HZ / BAUD < 1) ? 1 : CLK_HZ / BAUD;
  localparam int TICK_CLKS = (CLK_HZ / (BAUD * OVS) < 1) ? 1 : CLK_HZ / (BAUD * OVS);
  localparam int HALF_OVS  = (OVS / 2 < 1) ? 1 : OVS / 2;

  localparam logic [15:0] BIT_RELOAD  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] TICK_RELOAD = 16'(TICK_CLKS - 1);
  localparam logic [7:0]  HALF_RELOAD = 8'(HALF_OVS - 1);
  localparam logic [7:0]  OVS_RELOAD  = 8'(OVS - 1);
  localparam logic [3:0]  DB_LAST     = 4'(DATA_BITS - 1);
  localparam logic        HAS_PAR     = (PARITY != 0);
  localparam logic        ODD         = (PARITY == 1);
  localparam logic        STOP2       = (STOP_BITS == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_state_q;
  logic [15:0]          tx_cnt_q;
  logic [DATA_BITS-1:0] tx_sh_q;
  logic [3:0]           tx_bit_q;
  logic                 tx_stop_q;
  logic                 tx_par_q;
  logic                 tx_q;
  logic                 tx_busy_q;
  logic                 tx_load;

  assign Tx      = tx_q;
  assign Tx_busy = tx_busy_q;

  // A write landing on the edge that ends the final stop period starts the next frame directly.
  assign tx_load = wr_en && ((tx_state_q == S_IDLE) ||
                   (tx_state_q == S_STOP && tx_cnt_q == '0 && !tx_stop_q));

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_stop_q  <= 1'b0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
      tx_busy_q  <= 1'b0;
    end else if (tx_load) begin
      tx_state_q <= S_START;
      tx_cnt_q   <= BIT_RELOAD;
      tx_sh_q    <= data_in;
      tx_par_q   <= ODD ? ~^data_in : ^data_in;
      tx_q       <= 1'b0;
      tx_busy_q  <= 1'b1;
    end else if (tx_state_q != S_IDLE) begin
      if (tx_cnt_q != '0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= BIT_RELOAD;
        case (tx_state_q)
          S_START: begin
            tx_state_q <= S_DATA;
            tx_q       <= tx_sh_q[0];
            tx_sh_q    <= tx_sh_q >> 1;
            tx_bit_q   <= DB_LAST;
          end
          S_DATA: begin
            if (tx_bit_q != '0) begin
              tx_bit_q <= tx_bit_q - 4'd1;
              tx_q     <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
            end else if (HAS_PAR) begin
              tx_state_q <= S_PAR;
              tx_q       <= tx_par_q;
            end else begin
              tx_state_q <= S_STOP;
              tx_q       <= 1'b1;
              tx_stop_q  <= STOP2;
            end
          end
          S_PAR: begin
            tx_state_q <= S_STOP;
            tx_q       <= 1'b1;
            tx_stop_q  <= STOP2;
          end
          S_STOP: begin
            if (tx_stop_q) begin
              tx_stop_q <= 1'b0;
            end else begin
              tx_state_q <= S_IDLE;
              tx_busy_q  <= 1'b0;
            end
          end
          default: tx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------
  state_t               rx_state_q;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic [15:0]          rx_tcnt_q;
  logic [7:0]           rx_os_q;
  logic [3:0]           rx_bit_q;
  logic [DATA_BITS-1:0] rx_sh_q;
  logic                 rx_par_q;
  logic                 rx_tick;
  logic                 rx_sample;
  logic                 rx_done;
  logic                 rx_perr;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= Rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_tick   = (rx_state_q != S_IDLE) && (rx_tcnt_q == '0);
  assign rx_sample = rx_tick && (rx_os_q == '0);
  assign rx_done   = rx_sample && (rx_state_q == S_STOP);
  assign rx_perr   = HAS_PAR && ((^{rx_sh_q, rx_par_q}) != ODD);

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= S_IDLE;
      rx_tcnt_q  <= '0;
      rx_os_q    <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_par_q   <= 1'b0;
    end else begin
      // The tick divider restarts on each start edge so sample phase tracks the frame.
      if (rx_state_q == S_IDLE || rx_tcnt_q == '0) rx_tcnt_q <= TICK_RELOAD;
      else                                         rx_tcnt_q <= rx_tcnt_q - 16'd1;

      if (rx_state_q == S_IDLE) begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_q <= S_START;
          rx_os_q    <= HALF_RELOAD;
        end
      end else if (rx_tick && rx_os_q != '0) begin
        rx_os_q <= rx_os_q - 8'd1;
      end else if (rx_sample) begin
        rx_os_q <= OVS_RELOAD;
        case (rx_state_q)
          S_START: begin
            if (rx_sync_q) rx_state_q <= S_IDLE;
            else begin
              rx_state_q <= S_DATA;
              rx_bit_q   <= DB_LAST;
            end
          end
          S_DATA: begin
            rx_sh_q <= {rx_sync_q, rx_sh_q[DATA_BITS-1:1]};
            if (rx_bit_q != '0)  rx_bit_q   <= rx_bit_q - 4'd1;
            else if (HAS_PAR)    rx_state_q <= S_PAR;
            else                 rx_state_q <= S_STOP;
          end
          S_PAR: begin
            rx_par_q   <= rx_sync_q;
            rx_state_q <= S_STOP;
          end
          default: rx_state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      data_out   <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (rx_done && (!ready || ready_clr)) begin
      ready      <= 1'b1;
      data_out   <= rx_sh_q;
      parity_err <= rx_perr;
      frame_err  <= !rx_sync_q;
      overrun    <= 1'b0;
    end else if (rx_done) begin
      overrun <= 1'b1;
    end else if (ready_clr) begin
      ready      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: 8N1 loopback, 7E2 transmit waveform, and an
// 8O1 receiver driven with hand-built frames for error flag behaviour.
module tb_uart_cfg;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // 8N1 loopback instance
  logic [7:0] din_a, dout_a;
  logic wr_a, tx_a, busy_a, rdy_a, clr_a, pe_a, fe_a, ov_a;
  // 7E2 transmit instance
  logic [6:0] din_p, dout_p;
  logic wr_p, tx_p, busy_p, rx_p, rdy_p, clr_p, pe_p, fe_p, ov_p;
  // 8O1 receive instance
  logic [7:0] din_o, dout_o;
  logic wr_o, tx_o, busy_o, rx_o, rdy_o, clr_o, pe_o, fe_o, ov_o;

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVS(16), .DATA_BITS(8),
             .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_a), .wr_en(wr_a), .Tx(tx_a),
    .Tx_busy(busy_a), .Rx(tx_a), .ready(rdy_a), .ready_clr(clr_a),
    .data_out(dout_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a));

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVS(16), .DATA_BITS(7),
             .PARITY(2), .STOP_BITS(2)) dut_p (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_p), .wr_en(wr_p), .Tx(tx_p),
    .Tx_busy(busy_p), .Rx(rx_p), .ready(rdy_p), .ready_clr(clr_p),
    .data_out(dout_p), .parity_err(pe_p), .frame_err(fe_p), .overrun(ov_p));

  uart_cfg #(.CLK_HZ(1_600_000), .BAUD(100_000), .OVS(16), .DATA_BITS(8),
             .PARITY(1), .STOP_BITS(1)) dut_o (
    .clk_50m(clk), .rst_n(rst_n), .data_in(din_o), .wr_en(wr_o), .Tx(tx_o),
    .Tx_busy(busy_o), .Rx(rx_o), .ready(rdy_o), .ready_clr(clr_o),
    .data_out(dout_o), .parity_err(pe_o), .frame_err(fe_o), .overrun(ov_o));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] pay;
    logic       par;
    logic       stop;
    bit         clr;
    bit         glitch;
    logic       rdy;
    logic [7:0] dout;
    logic       perr;
    logic       ferr;
    logic       ovr;
  } rxv_t;

  rxv_t vec[6];

  task automatic rx_bit(input logic b);
    rx_o = b;
    repeat (16) @(negedge clk);
  endtask

  task automatic drive_frame(input logic [7:0] pay, input logic par, input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(pay[i]);
    rx_bit(par);
    rx_bit(stop);
    rx_bit(1'b1);
    rx_bit(1'b1);
  endtask

  task automatic lb_send(input logic [7:0] b);
    int n;
    n = 0;
    while (busy_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (busy_a) chk("lb_busy_timeout", 32'(busy_a), 32'd0);
    din_a = b;
    wr_a  = 1'b1;
    @(negedge clk);
    wr_a  = 1'b0;
  endtask

  task automatic lb_wait(output int cyc, output bit ok);
    cyc = 1;
    while (!rdy_a && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    ok = rdy_a;
  endtask

  task automatic lb_clear();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  initial begin
    logic [10:0] exp_frame;
    logic [7:0]  b;
    int          busy_cnt, cyc;
    bit          ok;

    vec[0] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vec[1] = '{8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
    vec[2] = '{8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b1};
    vec[3] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    vec[4] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vec[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};

    din_a = '0; wr_a = 0; clr_a = 0;
    din_p = '0; wr_p = 0; clr_p = 0; rx_p = 1'b1;
    din_o = '0; wr_o = 0; clr_o = 0; rx_o = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx_a), 32'd1);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_ready", 32'(rdy_a), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_flags", 32'({pe_a, fe_a, ov_a}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // 7E2: 0x55 -> start 0, 1010101, parity 0, stop 11
    exp_frame = 11'b11010101010;
    din_p = 7'h55;
    wr_p  = 1'b1;
    @(negedge clk);
    wr_p  = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      if (busy_p) busy_cnt++;
      if (c % 16 == 8 && c / 16 < 11)
        chk($sformatf("p_txbit%0d", c / 16), 32'(tx_p), 32'(exp_frame[c / 16]));
      @(negedge clk);
    end
    chk("p_busy_len", 32'(busy_cnt), 32'd176);
    chk("p_tx_idle", 32'(tx_p), 32'd1);

    // 8O1 receiver vectors
    for (int v = 0; v < 6; v++) begin
      if (vec[v].clr) begin
        clr_o = 1'b1;
        @(negedge clk);
        clr_o = 1'b0;
        chk($sformatf("o%0d_clr", v), 32'({rdy_o, pe_o, fe_o, ov_o}), 32'd0);
      end
      if (vec[v].glitch) begin
        rx_o = 1'b0;
        repeat (4) @(negedge clk);
        rx_o = 1'b1;
        repeat (200) @(negedge clk);
        chk($sformatf("o%0d_glitch_ready", v), 32'(rdy_o), 32'd0);
      end
      drive_frame(vec[v].pay, vec[v].par, vec[v].stop);
      chk($sformatf("o%0d_ready", v), 32'(rdy_o), 32'(vec[v].rdy));
      chk($sformatf("o%0d_dout", v), 32'(dout_o), 32'(vec[v].dout));
      chk($sformatf("o%0d_perr", v), 32'(pe_o), 32'(vec[v].perr));
      chk($sformatf("o%0d_ferr", v), 32'(fe_o), 32'(vec[v].ferr));
      chk($sformatf("o%0d_ovr", v), 32'(ov_o), 32'(vec[v].ovr));
    end

    // 8N1 loopback over every byte value starting at 0x03
    for (int i = 0; i < 256; i++) begin
      b = 8'(i + 3);
      lb_send(b);
      lb_wait(cyc, ok);
      if (!ok) chk("lb_ready_timeout", 32'(rdy_a), 32'd1);
      if (i == 0) chk("lb_latency_ok", 32'(cyc >= 145 && cyc <= 170), 32'd1);
      if (ok) begin
        chk($sformatf("lb_%02h", b), 32'(dout_a), 32'(b));
        chk($sformatf("lb_flags_%02h", b), 32'({pe_a, fe_a, ov_a}), 32'd0);
      end
      lb_clear();
    end

    // Reset in the middle of a data bit
    lb_send(8'h00);
    repeat (40) @(negedge clk);
    chk("mid_tx_low", 32'(tx_a), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx_a), 32'd1);
    chk("mid_rst_busy", 32'(busy_a), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_ready", 32'(rdy_a), 32'd0);
    lb_send(8'h3C);
    lb_wait(cyc, ok);
    chk("post_rst_rx_ready", 32'(ok), 32'd1);
    chk("post_rst_dout", 32'(dout_a), 32'h3C);
    chk("post_rst_flags", 32'({pe_a, fe_a, ov_a}), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
